// File: rtl/decode_stage.sv
// Decode stage: instruction queue feeding a registered MIPS-subset decoder with load-use bubbles.
// Optional DECODE_ILLEGAL_TRAP_EN: flag undecodable instructions and freeze until reset or flush.

module decode_stage #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  // fetch side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  // execute side
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  // decoded controls
  output logic        branch,
  output logic        reg_write,
  output logic        mem_write,
  output logic        alu_src,
  output logic        jal,
  output logic [1:0]  jump,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [2:0]  alu_ctrl,
  // decoded fields
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] immediate,
  output logic [25:0] target,
  output logic        load_use_stall,
  output logic        illegal
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef struct packed {
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       jal;
    logic [1:0] jump;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_ctrl;
  } ctl_t;

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic        push;
  logic        can_load;
  logic        do_load;
  logic        do_bubble;
  logic        hazard;
  logic        trap_hold;
  logic [31:0] head;
  logic [5:0]  head_op;
  logic [5:0]  head_fn;
  logic        head_uses_rt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head    = mem_q[rd_ptr_q];
  assign head_op = head[31:26];
  assign head_fn = head[5:0];

  assign in_ready = (count_q < CntW'(FIFO_DEPTH)) && !trap_hold;
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= instruction;
    end
  end

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(do_load);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_load) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder (operates on the queue head)
  // ---------------------------------------------------------------------------
  ctl_t dec;
  logic dec_ill;

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    case (head_op)
      OpLw: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 2'b01;
      end
      OpSw: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OpJ: begin
        dec.jump = 2'b10;
      end
      OpJal: begin
        dec.reg_write  = 1'b1;
        dec.jal        = 1'b1;
        dec.jump       = 2'b10;
        dec.reg_dst    = 2'b10;
        dec.mem_to_reg = 2'b10;
      end
      OpBne: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = 3'd1;
      end
      OpAddi: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OpXori: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = 3'd2;
      end
      OpRtype: begin
        dec.reg_dst = 2'b01;
        case (head_fn)
          FnAdd: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = 3'd0;
          end
          FnSub: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = 3'd1;
          end
          FnSlt: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = 3'd3;
          end
          FnJr: begin
            dec.jump = 2'b01;
          end
          default: begin
            dec     = '0;
            dec_ill = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard against the most recently issued LW
  // ---------------------------------------------------------------------------
  logic       lw_valid_q;
  logic [4:0] lw_rt_q;

  assign head_uses_rt = (head_op == OpRtype) || (head_op == OpBne) || (head_op == OpSw);

  always_comb begin
    hazard = 1'b0;
    if (lw_valid_q && (lw_rt_q != 5'd0)) begin
      hazard = (head[25:21] == lw_rt_q) || (head_uses_rt && (head[20:16] == lw_rt_q));
    end
  end

  assign can_load  = (count_q != '0) && (!out_valid || out_ready) && !trap_hold;
  assign do_bubble = can_load && hazard;
  assign do_load   = can_load && !hazard;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  ctl_t        ctl_q;
  logic        out_valid_q;
  logic        stall_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [15:0] imm_q;
  logic [25:0] target_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      lw_valid_q  <= 1'b0;
      lw_rt_q     <= '0;
      ctl_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      target_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      lw_valid_q  <= 1'b0;
    end else begin
      stall_q <= do_bubble;
      if (do_bubble) begin
        out_valid_q <= 1'b0;
        lw_valid_q  <= 1'b0;
      end else if (do_load) begin
        out_valid_q <= 1'b1;
        ctl_q       <= dec;
        rs_q        <= head[25:21];
        rt_q        <= head[20:16];
        rd_q        <= head[15:11];
        imm_q       <= (head_op == OpJal) ? 16'd8 : head[15:0];
        target_q    <= head[25:0];
        lw_valid_q  <= (head_op == OpLw);
        lw_rt_q     <= head[20:16];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Once set, the queue stops accepting and loading until reset or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end else if (do_load && dec_ill) begin
      illegal_q <= 1'b1;
    end
  end

  assign trap_hold = illegal_q;
  assign illegal   = illegal_q;
`else
  logic unused_dec_ill;

  assign unused_dec_ill = dec_ill;
  assign trap_hold      = 1'b0;
  assign illegal        = 1'b0;
`endif

  assign out_valid      = out_valid_q;
  assign load_use_stall = stall_q;
  assign branch         = ctl_q.branch;
  assign reg_write      = ctl_q.reg_write;
  assign mem_write      = ctl_q.mem_write;
  assign alu_src        = ctl_q.alu_src;
  assign jal            = ctl_q.jal;
  assign jump           = ctl_q.jump;
  assign reg_dst        = ctl_q.reg_dst;
  assign mem_to_reg     = ctl_q.mem_to_reg;
  assign alu_ctrl       = ctl_q.alu_ctrl;
  assign Rs             = rs_q;
  assign Rt             = rt_q;
  assign Rd             = rd_q;
  assign immediate      = imm_q;
  assign target         = target_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model plus directed literal checks.
// Follows DECODE_ILLEGAL_TRAP_EN to pick the expected illegal-instruction behaviour.

module tb_decode_stage;

  localparam int unsigned D = 4;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] instruction;
  logic        branch, reg_write, mem_write, alu_src, jal;
  logic [1:0]  jump, reg_dst, mem_to_reg;
  logic [2:0]  alu_ctrl;
  logic [4:0]  Rs, Rt, Rd;
  logic [15:0] immediate;
  logic [25:0] target;
  logic        load_use_stall, illegal;

  decode_stage #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .branch(branch), .reg_write(reg_write), .mem_write(mem_write), .alu_src(alu_src),
    .jal(jal), .jump(jump), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_ctrl(alu_ctrl),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .immediate(immediate), .target(target),
    .load_use_stall(load_use_stall), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int st_cnt = 0;
  logic [15:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected controls straight from the opcode/funct table.
  typedef struct packed {
    logic       bad;
    logic       branch, reg_write, mem_write, alu_src, jal;
    logic [1:0] jump, reg_dst, mem_to_reg;
    logic [2:0] alu_ctrl;
  } exp_t;

  function automatic exp_t spec_ctl(input logic [31:0] w);
    exp_t e;
    e = '0;
    case (w[31:26])
      6'h23: begin e.reg_write = 1; e.alu_src = 1; e.mem_to_reg = 2'b01; end
      6'h2B: begin e.mem_write = 1; e.alu_src = 1; end
      6'h02: e.jump = 2'b10;
      6'h03: begin
        e.reg_write = 1; e.jal = 1; e.jump = 2'b10; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
      end
      6'h05: begin e.branch = 1; e.alu_ctrl = 3'd1; end
      6'h08: begin e.reg_write = 1; e.alu_src = 1; end
      6'h0E: begin e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = 3'd2; end
      6'h00: begin
        case (w[5:0])
          6'h20: begin e.reg_dst = 2'b01; e.reg_write = 1; e.alu_ctrl = 3'd0; end
          6'h22: begin e.reg_dst = 2'b01; e.reg_write = 1; e.alu_ctrl = 3'd1; end
          6'h2A: begin e.reg_dst = 2'b01; e.reg_write = 1; e.alu_ctrl = 3'd3; end
          6'h08: begin e.reg_dst = 2'b01; e.jump = 2'b01; end
          default: e.bad = 1;
        endcase
      end
      default: e.bad = 1;
    endcase
    return e;
  endfunction

  function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
    bit uses_rt;
    uses_rt = (w[31:26] == 6'h00) || (w[31:26] == 6'h05) || (w[31:26] == 6'h2B);
    return (r != 5'd0) && ((w[25:21] == r) || (uses_rt && (w[20:16] == r)));
  endfunction

  // Reference model: pending words in a queue, the presented word, and the LW record.
  logic [31:0] q[$];
  logic [31:0] m_word;
  bit          m_valid, m_stall, m_ill, m_lw;
  logic [4:0]  m_lw_rt;

  always @(posedge clk or negedge reset_n) begin : model
    bit   acc;
    exp_t e;
    if (!reset_n) begin
      q.delete();
      m_word = '0; m_valid = 0; m_stall = 0; m_ill = 0; m_lw = 0; m_lw_rt = '0;
    end else if (flush) begin
      q.delete();
      m_valid = 0; m_stall = 0; m_ill = 0; m_lw = 0;
    end else begin
      acc = in_valid && (q.size() < D) && !m_ill;
      if ((q.size() > 0) && (!m_valid || out_ready) && !m_ill) begin
        if (m_lw && reads_reg(q[0], m_lw_rt)) begin
          m_valid = 0; m_stall = 1; m_lw = 0;
        end else begin
          m_word  = q.pop_front();
          m_valid = 1; m_stall = 0;
          m_lw    = (m_word[31:26] == 6'h23);
          m_lw_rt = m_word[20:16];
          e = spec_ctl(m_word);
          if (TRAP && e.bad) m_ill = 1;
        end
      end else begin
        m_stall = 0;
        if (out_ready) m_valid = 0;
      end
      if (acc) q.push_back(instruction);
    end
  end

  always @(negedge clk) begin : compare
    exp_t e;
    if (reset_n) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, (q.size() < D) && !m_ill);
      chk("load_use_stall", load_use_stall, m_stall);
      chk("illegal", illegal, m_ill);
      if (m_valid) begin
        e = spec_ctl(m_word);
        chk("branch", branch, e.branch);
        chk("reg_write", reg_write, e.reg_write);
        chk("mem_write", mem_write, e.mem_write);
        chk("alu_src", alu_src, e.alu_src);
        chk("jal", jal, e.jal);
        chk("jump", jump, e.jump);
        chk("reg_dst", reg_dst, e.reg_dst);
        chk("mem_to_reg", mem_to_reg, e.mem_to_reg);
        chk("alu_ctrl", alu_ctrl, e.alu_ctrl);
        chk("Rs", Rs, m_word[25:21]);
        chk("Rt", Rt, m_word[20:16]);
        chk("Rd", Rd, m_word[15:11]);
        chk("immediate", immediate, (m_word[31:26] == 6'h03) ? 16'd8 : m_word[15:0]);
        chk("target", target, m_word[25:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && out_valid && out_ready) got.push_back(immediate);
    if (load_use_stall) st_cnt++;
  end

  task automatic drive(input logic [31:0] w);
    in_valid    = 1'b1;
    instruction = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush_case(input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid    = 1'b1;
      instruction = 32'h3800_0000 + i;
      @(negedge clk);
    end
    flush       = 1'b1;
    in_valid    = 1'b1;
    instruction = 32'h2000_00AA;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    got.delete();
    out_ready = 1'b1;
    idle(4);
    chk("flush_nothing_drained", got.size(), 0);
  endtask

  initial begin
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instruction = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_Rs", Rs, 5'd0);
    chk("rst_target", target, 26'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_stall", load_use_stall, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Single ADD into an empty block.
    out_ready = 1'b1;
    drive(32'h012A_4020);
    @(negedge clk);
    chk("add_out_valid", out_valid, 1'b1);
    chk("add_reg_write", reg_write, 1'b1);
    chk("add_reg_dst", reg_dst, 2'b01);
    chk("add_alu_ctrl", alu_ctrl, 3'd0);
    chk("add_Rs", Rs, 5'd9);
    chk("add_Rt", Rt, 5'd10);
    chk("add_Rd", Rd, 5'd8);
    @(negedge clk);
    chk("add_consumed", out_valid, 1'b0);

    // Backpressure: 4 queued + 1 presented, then ordered drain.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("bp_in_ready_open", in_ready, 1'b1);
      in_valid    = 1'b1;
      instruction = 32'h2000_0000 + i;
      @(negedge clk);
    end
    chk("bp_in_ready_full", in_ready, 1'b0);
    instruction = 32'h2000_0006;
    @(negedge clk);
    chk("bp_in_ready_held", in_ready, 1'b0);
    in_valid = 1'b0;
    got.delete();
    out_ready = 1'b1;
    idle(8);
    chk("bp_drain_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) chk("bp_drain_order", got[k], k + 1);

    // Load-use: LW $9 then ADD reading $9.
    st_cnt = 0;
    drive(32'h8D09_0000);
    drive(32'h012A_4020);
    chk("lu_lw_valid", out_valid, 1'b1);
    chk("lu_lw_Rt", Rt, 5'd9);
    @(negedge clk);
    chk("lu_bubble_valid", out_valid, 1'b0);
    chk("lu_bubble_stall", load_use_stall, 1'b1);
    @(negedge clk);
    chk("lu_add_valid", out_valid, 1'b1);
    chk("lu_add_stall", load_use_stall, 1'b0);
    chk("lu_add_Rd", Rd, 5'd8);
    idle(3);
    chk("lu_stall_cycles", st_cnt, 1);

    // LW to $0 never stalls.
    st_cnt = 0;
    drive(32'h8D00_0000);
    drive(32'h0000_4020);
    chk("lu0_lw_valid", out_valid, 1'b1);
    @(negedge clk);
    chk("lu0_add_valid", out_valid, 1'b1);
    chk("lu0_add_Rd", Rd, 5'd8);
    idle(3);
    chk("lu0_stall_cycles", st_cnt, 0);

    // Flush with full queue, then with partially filled queue, each with a same-cycle push.
    flush_case(5);
    flush_case(3);

    // JAL plus a decode sweep checked by the model (includes an SW load-use on Rt).
    drive(32'h0C00_0010);
    @(negedge clk);
    chk("jal_jal", jal, 1'b1);
    chk("jal_immediate", immediate, 16'd8);
    chk("jal_reg_dst", reg_dst, 2'b10);
    chk("jal_mem_to_reg", mem_to_reg, 2'b10);
    chk("jal_jump", jump, 2'b10);
    drive(32'h0800_0004);
    drive(32'h1509_0003);
    drive(32'h3909_00FF);
    drive(32'h012A_4022);
    drive(32'h012A_402A);
    drive(32'h0100_0008);
    drive(32'h8D09_0000);
    drive(32'hAD09_0004);
    idle(4);

    // Undecodable opcode 0x3F.
    drive(32'hFC00_0000);
    @(negedge clk);
    chk("ill_out_valid", out_valid, 1'b1);
    chk("ill_reg_write", reg_write, 1'b0);
    chk("ill_alu_src", alu_src, 1'b0);
    chk("ill_jump", jump, 2'b00);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", illegal, 1'b1);
    chk("ill_in_ready", in_ready, 1'b0);
    in_valid    = 1'b1;
    instruction = 32'h012A_4020;
    idle(3);
    in_valid = 1'b0;
    chk("ill_hold_in_ready", in_ready, 1'b0);
    chk("ill_hold_flag", illegal, 1'b1);
    chk("ill_hold_out_valid", out_valid, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("ill_flush_flag", illegal, 1'b0);
    chk("ill_flush_in_ready", in_ready, 1'b1);
`else
    chk("nop_flag", illegal, 1'b0);
    chk("nop_in_ready", in_ready, 1'b1);
    drive(32'h012A_4020);
    @(negedge clk);
    chk("nop_next_valid", out_valid, 1'b1);
    chk("nop_next_Rd", Rd, 5'd8);
`endif
    idle(2);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    drive(32'h2000_0011);
    drive(32'h2000_0012);
    drive(32'h2000_0013);
    chk("rst2_pre_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_reg_write", reg_write, 1'b0);
    chk("rst2_alu_src", alu_src, 1'b0);
    chk("rst2_immediate", immediate, 16'd0);
    chk("rst2_Rs", Rs, 5'd0);
    chk("rst2_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst2_release_in_ready", in_ready, 1'b1);
    got.delete();
    out_ready = 1'b1;
    idle(4);
    chk("rst2_dropped", got.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, instruction input 32: fetch-side handshake.
REQ-005 SHALL have ports out_valid output 1, out_ready input 1: execute-side handshake.
REQ-006 SHALL have port flush  input  1  discard all queued and presented instructions.
REQ-007 SHALL have outputs branch, reg_write, mem_write, alu_src, jal (1 each); jump, reg_dst, mem_to_reg (2 each); alu_ctrl (3).
REQ-008 SHALL have outputs Rs, Rt, Rd (5 each), immediate (16), target (26): registered instruction fields.
REQ-009 SHALL have outputs load_use_stall (1), bubble-cycle flag, and illegal (1), sticky illegal-instruction flag.

Function
REQ-010 SHALL push instruction into the FIFO on in_valid && in_ready; in_ready = (count < FIFO_DEPTH), with no same-cycle pass when full.
REQ-011 SHALL load the FIFO head into the output register when FIFO non-empty and (!out_valid || out_ready); empty FIFO with out_ready clears out_valid.
REQ-012 SHALL present an instruction accepted at edge N on out_valid at edge N+1 when the FIFO and output register were empty (1-cycle latency).
REQ-013 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-014 SHALL wrap read/write pointers modulo FIFO_DEPTH; count SHALL be width clog2(FIFO_DEPTH)+1.
REQ-015 SHALL decode opcodes: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, ADDI 0x08, XORI 0x0E, R-type 0x00 (funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08).
REQ-016 SHALL drive controls: LW rw=1 alu_src=1 mem_to_reg=01; SW mem_write=1 alu_src=1; J jump=10; JAL rw=1 jal=1 jump=10 reg_dst=10 mem_to_reg=10 immediate=8; BNE branch=1 alu_ctrl=1; ADDI rw=1 alu_src=1; XORI rw=1 alu_src=1 alu_ctrl=2.
REQ-017 SHALL drive R-types reg_dst=01, rw=1, alu_ctrl ADD 0 / SUB 1 / SLT 3; JR rw=0 jump=01.
REQ-018 SHALL drive every control not listed for a decode to 0 (no X outputs).
REQ-019 SHALL copy Rs=[25:21], Rt=[20:16], Rd=[15:11], immediate=[15:0] (except JAL), target=[25:0] on every load.
REQ-020 SHALL record last-issued LW Rt; if next head reads a nonzero matching register (Rs always; Rt for R-type, BNE, SW), SHALL issue one bubble (out_valid=0, load_use_stall=1 one cycle), then load head.
REQ-021 SHALL clear the LW record on any non-LW load or bubble.
REQ-022 SHALL on flush empty the FIFO, clear out_valid and LW record next edge; flush SHALL win over a simultaneous push or load.

Reset
REQ-023 SHALL on reset_n low immediately clear FIFO count/pointers, out_valid, load_use_stall, illegal, LW record, and all control/field outputs to 0.
REQ-024 SHALL drive in_ready=1 from reset release; reset mid-transfer SHALL drop the in-flight instruction.

Configuration
REQ-025 SHALL with DECODE_ILLEGAL_TRAP_EN defined set illegal=1 on loading an undecodable opcode/funct, present it with all controls 0, then hold in_ready=0 and load nothing further until reset or flush clears illegal.
REQ-026 SHALL without DECODE_ILLEGAL_TRAP_EN decode undecodable instructions as NOP (all controls 0), tie illegal=0, never stall.

Verification
REQ-027 SHALL test: single ADD 0x012A4020 into empty block -> out_valid next cycle, rw=1 reg_dst=01 alu_ctrl=0 Rs=9 Rt=10 Rd=8.
REQ-028 SHALL test: out_ready=0, push 5 words with FIFO_DEPTH=4 -> in_ready low after 4 FIFO + 1 output entry, order preserved on drain.
REQ-029 SHALL test: LW 0x8D090000 then ADD reading $9 -> one bubble, load_use_stall=1 one cycle; with $0 target -> no bubble.
REQ-030 SHALL test: flush with FIFO full and push same cycle -> next cycle out_valid=0, count 0, pushed word dropped.
REQ-031 SHALL test: opcode 0x3F with macro -> illegal=1, in_ready=0 until flush; without -> NOP, illegal=0.
REQ-032 SHALL test: reset_n low mid-stream -> all outputs 0 asynchronously, in_ready=1 after release.
